// File: rtl/armleo_regfile_mr1w.sv
// armleo_regfile_mr1w: multi-read single-write register file with post-reset clear,
// optional same-cycle write forwarding and a hardwired zero register.
module armleo_regfile_mr1w #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    parameter int CLEAR_ALL  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready,
    input  logic [NUM_READ-1:0]            rs_read,
    input  logic [NUM_READ*DEPTH_LOG2-1:0] rs_addr,
    output logic [NUM_READ*WIDTH-1:0]      rs_rdata,
    input  logic                           rd_write,
    input  logic [DEPTH_LOG2-1:0]          rd_addr,
    input  logic [WIDTH-1:0]               rd_wdata
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    typedef enum logic {CLEAR, READY} state_t;
    state_t                         state_q, state_d;
    logic [DEPTH_LOG2:0]            clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]               mem [DEPTH];
    logic [NUM_READ-1:0][WIDTH-1:0] rdata_q, rdata_d;
    logic                           clearing, wr_zero, we;
    logic [DEPTH_LOG2-1:0]          waddr;
    logic [WIDTH-1:0]               wdata;

    assign clearing = state_q == CLEAR;
    assign ready    = state_q == READY;
    assign rs_rdata = rdata_q;
    assign wr_zero  = ZERO_REG != 0 && rd_addr == '0;
    // The clear sequence borrows the single write port, so user writes are dropped meanwhile.
    assign we       = clearing ? CLEAR_ALL != 0 : rd_write && !wr_zero;
    assign waddr    = clearing ? clr_cnt_q[DEPTH_LOG2-1:0] : rd_addr;
    assign wdata    = clearing ? '0 : rd_wdata;

    always_comb begin
        clr_cnt_d = clearing ? clr_cnt_q + 1'b1 : clr_cnt_q;
        state_d   = clearing && (CLEAR_ALL == 0 || clr_cnt_q == (DEPTH_LOG2+1)'(DEPTH - 1)) ? READY : state_q;
        for (int i = 0; i < NUM_READ; i++)
            rdata_d[i] = (ZERO_REG != 0 && rs_addr[i*DEPTH_LOG2 +: DEPTH_LOG2] == '0) ? '0 :
                         (BYPASS != 0 && rd_write && rd_addr == rs_addr[i*DEPTH_LOG2 +: DEPTH_LOG2]) ? rd_wdata :
                         mem[rs_addr[i*DEPTH_LOG2 +: DEPTH_LOG2]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            for (int i = 0; i < NUM_READ; i++)
                if (ready && rs_read[i]) rdata_q[i] <= rdata_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: doc/armleo_regfile_mr1w.md
ARMLEO_REGFILE_MR1W -- requirements
Module: armleo_regfile_mr1w

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of one register in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, address width; depth = 2**DEPTH_LOG2.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write contents.
REQ-005 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero, writes to it ignored.
REQ-006 SHALL have parameter CLEAR_ALL, default 1, 1 = all registers zeroed by a post-reset clear sequence.
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port ready  output  1  high when the block accepts reads and writes.
REQ-010 SHALL have port rs_read  input  NUM_READ  per-port read enable.
REQ-011 SHALL have port rs_addr  input  NUM_READ*DEPTH_LOG2  per-port read address, port i at bits [i*DEPTH_LOG2 +: DEPTH_LOG2].
REQ-012 SHALL have port rs_rdata  output  NUM_READ*WIDTH  per-port registered read data, port i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port rd_write  input  1  write enable.
REQ-014 SHALL have port rd_addr  input  DEPTH_LOG2  write address.
REQ-015 SHALL have port rd_wdata  input  WIDTH  write data.

Function
REQ-016 SHALL implement two states: CLEAR (ready=0) and READY (ready=1).
REQ-017 SHALL, in CLEAR, write zero to address clr_cnt each cycle, incrementing clr_cnt from 0 to 2**DEPTH_LOG2-1, entering READY the cycle after writing the last address (exactly 2**DEPTH_LOG2 cycles after rst_n rises).
REQ-018 SHALL, when CLEAR_ALL=0, enter READY on the first rising edge after rst_n rises, with register contents undefined except per REQ-023.
REQ-019 SHALL, in CLEAR, ignore rd_write and rs_read; rs_rdata holds its current value.
REQ-020 SHALL, in READY, write rd_wdata to rd_addr at the rising edge when rd_write=1, except address 0 when ZERO_REG=1.
REQ-021 SHALL, in READY, when rs_read[i]=1 at a rising edge, update port i rs_rdata with register rs_addr[i] (1-cycle latency); when rs_read[i]=0, port i holds its previous value.
REQ-022 SHALL, when BYPASS=1 and rd_write=1 with rd_addr==rs_addr[i] and rs_read[i]=1 in the same cycle (and not the ZERO_REG case), return rd_wdata on port i; when BYPASS=0 return the pre-write contents.
REQ-023 SHALL return zero for any read of address 0 when ZERO_REG=1, regardless of BYPASS or prior writes.
REQ-024 SHALL allow all read ports to read the same or different addresses in the same cycle with no stall and no mutual effect.
REQ-025 SHALL keep clr_cnt DEPTH_LOG2+1 bits wide so the final-address terminal condition does not wrap to 0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force ready=0, rs_rdata=0 on all ports, clr_cnt=0, state=CLEAR.
REQ-027 SHALL, on rst_n asserted mid-clear or mid-operation, abandon the current sequence and restart CLEAR from address 0 after deassertion.
REQ-028 SHALL not require the storage array itself to be reset; zeroing is by the clear sequence only.

Verification
REQ-029 Reset release, defaults (32/5/2): count cycles -> ready=1 exactly 32 cycles after rst_n rises; every address reads 0x00000000.
REQ-030 Write 0xDEADBEEF to addr 5, next cycle read addr 5 on both ports -> both rs_rdata = 0xDEADBEEF one cycle later.
REQ-031 Same cycle: write 0x12345678 to addr 7, port0 reads addr 7 -> port0 = 0x12345678 with BYPASS=1; port0 = prior value (0) with BYPASS=0.
REQ-032 Write 0xFFFFFFFF to addr 0 with ZERO_REG=1, then read addr 0 (including same-cycle bypass attempt) -> rs_rdata = 0.
REQ-033 rst_n pulsed low at clear cycle 10 -> ready and rs_rdata go 0 immediately; ready rises 32 cycles after rst_n release; rd_write during CLEAR leaves target register 0.
REQ-034 NUM_READ=4: four ports read addrs 1,2,3,1 after writing 0x11,0x22,0x33 -> outputs 0x11,0x22,0x33,0x11; port with rs_read=0 holds its prior value.
